// File: rtl/csv_acc_resolve_if.sv
// Handshake bundle for csv_acc_resolve: carry-save pair input stream and binary result output.
interface csv_acc_resolve_if #(
  parameter int unsigned width = 16
) ();
  logic             InValid;
  logic             InReady;
  logic [width-1:0] InS;
  logic [width-1:0] InC;
  logic             InLast;
  logic             OutValid;
  logic             OutReady;
  logic [width-1:0] OutZ;

  modport master (
    output InValid, InS, InC, InLast, OutReady,
    input  InReady, OutValid, OutZ
  );

  modport slave (
    input  InValid, InS, InC, InLast, OutReady,
    output InReady, OutValid, OutZ
  );
endinterface

// File: rtl/csv_acc_resolve.sv
// Carry-save accumulator with a chunked multi-cycle carry-propagate resolve.
// Optional synchronous clear port Clr is enabled by defining ELAU_CSV_ACC_CLR_EN.
module csv_acc_resolve #(
  parameter int unsigned width = 16,
  parameter int unsigned chunk = 4
) (
  input logic CLK,
  input logic RST,
`ifdef ELAU_CSV_ACC_CLR_EN
  input logic Clr,
`endif
  csv_acc_resolve_if.slave bus
);

  localparam int unsigned N    = (width + chunk - 1) / chunk;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(N - 1);
  localparam logic [width-1:0] ChunkMask = {width{1'b1}} >> (width - chunk);

  typedef enum logic [1:0] {StAcc, StWait, StResolve, StOut} state_e;

  state_e           state_q, state_d;
  logic [width-1:0] acc_s_q, acc_s_d;
  logic [width-1:0] acc_c_q, acc_c_d;
  logic [width-1:0] res_q, res_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             cy_q, cy_d;

  // 4:2 compression as two stacked 3:2 layers; carries shift left and the MSB drops.
  logic [width-1:0] s1, c1, s2, c2;
  assign s1 = acc_s_q ^ acc_c_q ^ bus.InS;
  assign c1 = ((acc_s_q & acc_c_q) | (acc_s_q & bus.InS) | (acc_c_q & bus.InS)) << 1;
  assign s2 = s1 ^ c1 ^ bus.InC;
  assign c2 = ((s1 & c1) | (s1 & bus.InC) | (c1 & bus.InC)) << 1;

  // One chunk of the carry-propagate add; the top chunk is masked short by the shift.
  logic [31:0]      lo;
  logic [width:0]   csum;
  logic [width-1:0] res_chunk;
  assign lo   = 32'(idx_q) * chunk;
  assign csum = {1'b0, (acc_s_q >> lo) & ChunkMask} + {1'b0, (acc_c_q >> lo) & ChunkMask}
              + (width + 1)'(cy_q);
  assign res_chunk = (res_q & ~(ChunkMask << lo)) | ((csum[width-1:0] & ChunkMask) << lo);

  assign bus.InReady  = (state_q == StAcc);
  assign bus.OutValid = (state_q == StOut);
  assign bus.OutZ     = res_q;

  always_comb begin
    state_d = state_q;
    acc_s_d = acc_s_q;
    acc_c_d = acc_c_q;
    res_d   = res_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    unique case (state_q)
      StAcc: begin
        if (bus.InValid) begin
          acc_s_d = s2;
          acc_c_d = c2;
          if (bus.InLast) begin
            state_d = StWait;
            idx_d   = '0;
            cy_d    = 1'b0;
          end
        end
      end
      // Turnaround cycle that sets the accept-to-valid latency at n+1.
      StWait: state_d = StResolve;
      StResolve: begin
        res_d = res_chunk;
        cy_d  = csum[chunk];
        if (idx_q == LastIdx) begin
          state_d = StOut;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StOut: begin
        if (bus.OutReady) begin
          acc_s_d = '0;
          acc_c_d = '0;
          state_d = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
`ifdef ELAU_CSV_ACC_CLR_EN
    if (Clr) begin
      state_d = StAcc;
      acc_s_d = '0;
      acc_c_d = '0;
      idx_d   = '0;
      cy_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StAcc;
      acc_s_q <= '0;
      acc_c_q <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_s_q <= acc_s_d;
      acc_c_q <= acc_c_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
    end
  end

endmodule

// File: tb/tb_csv_acc_resolve.sv
// Directed bench for csv_acc_resolve: a 16/4 instance and a 10/4 instance on one clock.
module tb_csv_acc_resolve;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  csv_acc_resolve_if #(.width(16)) b16 ();
  csv_acc_resolve_if #(.width(10)) b10 ();

  csv_acc_resolve #(.width(16), .chunk(4)) u16 (.CLK(CLK), .RST(RST), .bus(b16));
  csv_acc_resolve #(.width(10), .chunk(4)) u10 (.CLK(CLK), .RST(RST), .bus(b10));

  typedef struct {
    int               nb;
    logic [2:0][15:0] s;
    logic [2:0][15:0] c;
    logic [15:0]      z;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input int nb, input logic [15:0] s0, c0, s1, c1, s2, c2,
                              input logic [15:0] z);
    vec_t v;
    v.nb = nb;
    v.s[0] = s0; v.c[0] = c0;
    v.s[1] = s1; v.c[1] = c1;
    v.s[2] = s2; v.c[2] = c2;
    v.z = z;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send16(input logic [15:0] s, input logic [15:0] c, input logic last);
    b16.InS = s; b16.InC = c; b16.InLast = last; b16.InValid = 1'b1;
    check("in_ready_acc16", 32'(b16.InReady), 1);
    tick();
    b16.InValid = 1'b0;
    b16.InLast  = 1'b0;
  endtask

  task automatic send10(input logic [9:0] s, input logic [9:0] c);
    b10.InS = s; b10.InC = c; b10.InLast = 1'b1; b10.InValid = 1'b1;
    check("in_ready_acc10", 32'(b10.InReady), 1);
    tick();
    b10.InValid = 1'b0;
    b10.InLast  = 1'b0;
  endtask

  // Called right after the accepting edge; counts edges until OutValid.
  task automatic await16(input string tag, input int exp_lat, input logic [15:0] exp_z);
    int cyc = 0;
    bit ready_hi = 1'b0;
    while (b16.OutValid !== 1'b1 && cyc < 40) begin
      if (b16.InReady !== 1'b0) ready_hi = 1'b1;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_ready_low"}, 32'(ready_hi | b16.InReady), 0);
    check({tag, "_outz"}, 32'(b16.OutZ), 32'(exp_z));
  endtask

  task automatic handshake16(input string tag, input logic [15:0] exp_z);
    b16.OutReady = 1'b1;
    tick();
    b16.OutReady = 1'b0;
    check({tag, "_valid_drop"}, 32'(b16.OutValid), 0);
    check({tag, "_ready_back"}, 32'(b16.InReady), 1);
    check({tag, "_outz_hold"}, 32'(b16.OutZ), 32'(exp_z));
  endtask

  task automatic await10(input string tag, input logic [9:0] exp_z);
    int cyc = 0;
    while (b10.OutValid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 4);
    check({tag, "_outz"}, 32'(b10.OutZ), 32'(exp_z));
    b10.OutReady = 1'b1;
    tick();
    b10.OutReady = 1'b0;
    check({tag, "_valid_drop"}, 32'(b10.OutValid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(1, 16'h1234, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1235);
    vecs[1] = mk(3, 16'h00FF, 16'h0001, 16'h0F00, 16'h0100, 16'h0001, 16'h0000, 16'h1101);
    vecs[2] = mk(2, 16'hFFFF, 16'h0001, 16'h0002, 16'h0000, 16'h0, 16'h0, 16'h0002);
    vecs[3] = mk(2, 16'h8000, 16'h8000, 16'h1234, 16'h4321, 16'h0, 16'h0, 16'h5555);
    vecs[4] = mk(3, 16'hAAAA, 16'h5555, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFE);
    vecs[5] = mk(1, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000);

    b16.InValid = 1'b0; b16.InS = '0; b16.InC = '0; b16.InLast = 1'b0; b16.OutReady = 1'b0;
    b10.InValid = 1'b0; b10.InS = '0; b10.InC = '0; b10.InLast = 1'b0; b10.OutReady = 1'b0;

    RST = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(b16.InReady), 1);
    check("rst_out_valid", 32'(b16.OutValid), 0);
    check("rst_outz", 32'(b16.OutZ), 0);
    RST = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vecs[v].nb; b++) begin
        send16(vecs[v].s[b], vecs[v].c[b], b == vecs[v].nb - 1);
      end
      await16($sformatf("vec%0d", v), 5, vecs[v].z);
      handshake16($sformatf("vec%0d", v), vecs[v].z);
    end

    // Backpressure: input traffic must be ignored while the result waits.
    send16(16'h0007, 16'h0001, 1'b1);
    await16("bp", 5, 16'h0008);
    for (int i = 0; i < 10; i++) begin
      b16.InValid = 1'b1;
      b16.InS = 16'($urandom);
      b16.InC = 16'($urandom);
      b16.InLast = 1'($urandom);
      tick();
      check("bp_valid", 32'(b16.OutValid), 1);
      check("bp_ready", 32'(b16.InReady), 0);
      check("bp_outz", 32'(b16.OutZ), 16'h0008);
    end
    b16.OutReady = 1'b1;
    tick();
    b16.OutReady = 1'b0;
    b16.InValid = 1'b0;
    b16.InLast = 1'b0;
    check("bp_release", 32'(b16.InReady), 1);
    send16(16'h0005, 16'h0000, 1'b1);
    await16("bp_next", 5, 16'h0005);
    handshake16("bp_next", 16'h0005);

    // Narrow instance: n=3 with a 2-bit top chunk.
    send10(10'h3FF, 10'h001);
    await10("w10_wrap", 10'h000);
    send10(10'h155, 10'h0AB);
    await10("w10_mix", 10'h200);

    // Reset mid-resolve abandons the packet and clears the result.
    send16(16'h1234, 16'h0000, 1'b1);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mrst_valid", 32'(b16.OutValid), 0);
    check("mrst_ready", 32'(b16.InReady), 1);
    check("mrst_outz", 32'(b16.OutZ), 0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (b16.OutValid !== 1'b0) seen = 1'b1;
      end
      check("mrst_no_output", 32'(seen), 0);
    end
    send16(16'h0010, 16'h0001, 1'b1);
    await16("mrst_next", 5, 16'h0011);
    handshake16("mrst_next", 16'h0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
